// File: rtl/cordic_arbiter.sv
// Round-robin front-end sharing one cordic_pipeline between four requesters.
// An id tag travels alongside each issued triple and routes the result back.
module cordic_arbiter #(
  parameter int W       = 16,
  parameter int LATENCY = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [3:0]     req_valid,
  output logic [3:0]     req_ready,
  input  logic [4*W-1:0] req_x,
  input  logic [4*W-1:0] req_y,
  input  logic [4*W-1:0] req_z,
  output logic [W-1:0]   cp_x0,
  output logic [W-1:0]   cp_y0,
  output logic [W-1:0]   cp_z0,
  input  logic [W-1:0]   cp_out_x,
  input  logic [W-1:0]   cp_out_y,
  input  logic [W-1:0]   cp_out_z,
  output logic           rsp_valid,
  output logic [1:0]     rsp_id,
  output logic [W-1:0]   rsp_x,
  output logic [W-1:0]   rsp_y,
  output logic [W-1:0]   rsp_z
);

  // Returns {found, id}; candidates scanned from last+4 down to last+1 so last+1 wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] pick;
    logic [1:0] cand;
    pick = {1'b0, last};
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (req[cand]) begin
        pick = {1'b1, cand};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  logic [1:0]   last_r;
  logic [2:0]   pick_s;
  logic [3:0]   ready_s;
  logic         hs_s;
  logic [W-1:0] sel_x_s;
  logic [W-1:0] sel_y_s;
  logic [W-1:0] sel_z_s;

  // Tag stage 0 sits beside the cp_* registers; stage j lines up with pipeline stage j.
  logic         tag_vld_r [0:LATENCY];
  logic [1:0]   tag_id_r  [0:LATENCY];

  // Grant selection and winner operand mux.
  always_comb begin
    pick_s  = rr_pick(req_valid & {4{en}}, last_r);
    ready_s = 4'b0000;
    if (pick_s[2] && rst_n) begin
      ready_s[pick_s[1:0]] = 1'b1;
    end else begin
      ready_s = 4'b0000;
    end
    hs_s    = |(ready_s & req_valid);
    sel_x_s = req_x[int'(pick_s[1:0]) * W +: W];
    sel_y_s = req_y[int'(pick_s[1:0]) * W +: W];
    sel_z_s = req_z[int'(pick_s[1:0]) * W +: W];
  end

  assign req_ready = ready_s;

  // Operand registers into the pipeline and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cp_x0  <= '0;
      cp_y0  <= '0;
      cp_z0  <= '0;
      last_r <= 2'd3;
    end else if (hs_s) begin
      cp_x0  <= sel_x_s;
      cp_y0  <= sel_y_s;
      cp_z0  <= sel_z_s;
      last_r <= pick_s[1:0];
    end else begin
      cp_x0  <= cp_x0;
      cp_y0  <= cp_y0;
      cp_z0  <= cp_z0;
      last_r <= last_r;
    end
  end

  // Free-running tag shift register; never stalls, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= LATENCY; i++) begin
        tag_vld_r[i] <= 1'b0;
        tag_id_r[i]  <= 2'd0;
      end
    end else begin
      tag_vld_r[0] <= hs_s;
      tag_id_r[0]  <= pick_s[1:0];
      for (int i = 1; i <= LATENCY; i++) begin
        tag_vld_r[i] <= tag_vld_r[i-1];
        tag_id_r[i]  <= tag_id_r[i-1];
      end
    end
  end

  // Response capture; payload only updates on a valid tag so stale pipeline data is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 2'd0;
      rsp_x     <= '0;
      rsp_y     <= '0;
      rsp_z     <= '0;
    end else if (tag_vld_r[LATENCY]) begin
      rsp_valid <= 1'b1;
      rsp_id    <= tag_id_r[LATENCY];
      rsp_x     <= cp_out_x;
      rsp_y     <= cp_out_y;
      rsp_z     <= cp_out_z;
    end else begin
      rsp_valid <= 1'b0;
      rsp_id    <= rsp_id;
      rsp_x     <= rsp_x;
      rsp_y     <= rsp_y;
      rsp_z     <= rsp_z;
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter with a behavioural delay-line pipeline stub.
module tb_cordic_arbiter;
  localparam int W = 16;
  localparam int L = 16;

  logic           clk;
  logic           rst_n;
  logic           en;
  logic [3:0]     req_valid;
  logic [3:0]     req_ready;
  logic [4*W-1:0] req_x, req_y, req_z;
  logic [W-1:0]   cp_x0, cp_y0, cp_z0;
  logic [W-1:0]   cp_out_x, cp_out_y, cp_out_z;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_x, rsp_y, rsp_z;

  cordic_arbiter #(.W(W), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .cp_x0(cp_x0), .cp_y0(cp_y0), .cp_z0(cp_z0),
    .cp_out_x(cp_out_x), .cp_out_y(cp_out_y), .cp_out_z(cp_out_z),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z)
  );

  // Pipeline stub: L-stage delay line returning (x+1, y+2, z+3), no reset.
  logic [W-1:0] dx [L];
  logic [W-1:0] dy [L];
  logic [W-1:0] dz [L];
  always @(posedge clk) begin
    dx[0] <= cp_x0 + 16'd1;
    dy[0] <= cp_y0 + 16'd2;
    dz[0] <= cp_z0 + 16'd3;
    for (int i = 1; i < L; i++) begin
      dx[i] <= dx[i-1];
      dy[i] <= dy[i-1];
      dz[i] <= dz[i-1];
    end
  end
  assign cp_out_x = dx[L-1];
  assign cp_out_y = dy[L-1];
  assign cp_out_z = dz[L-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    int         due;
    logic [1:0] id;
    logic [W-1:0] x, y, z;
  } exp_t;
  exp_t sb_q[$];
  exp_t e;

  logic [1:0]   m_last;
  logic [W-1:0] m_cp_x, m_cp_y, m_cp_z;
  logic [1:0]   m_rsp_id;
  logic [W-1:0] m_rsp_x, m_rsp_y, m_rsp_z;
  logic [3:0]   m_ready;
  int           m_pick;
  int           cand;

  // Reference model: checks grants, cp hold, responses; pushes expectations on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      check_eq("rst_ready", {28'd0, req_ready}, 32'd0);
      check_eq("rst_cp", {cp_x0, cp_y0}, 32'd0);
      check_eq("rst_cpz", {16'd0, cp_z0}, 32'd0);
      check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_eq("rst_rsp", {rsp_x, rsp_y}, 32'd0);
      check_eq("rst_rsp_zid", {14'd0, rsp_id, rsp_z}, 32'd0);
      sb_q.delete();
      m_last = 2'd3;
      m_cp_x = '0; m_cp_y = '0; m_cp_z = '0;
      m_rsp_id = 2'd0; m_rsp_x = '0; m_rsp_y = '0; m_rsp_z = '0;
    end else begin
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        e = sb_q.pop_front();
        check_eq("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("rsp_id", {30'd0, rsp_id}, {30'd0, e.id});
        check_eq("rsp_x", {16'd0, rsp_x}, {16'd0, e.x});
        check_eq("rsp_y", {16'd0, rsp_y}, {16'd0, e.y});
        check_eq("rsp_z", {16'd0, rsp_z}, {16'd0, e.z});
        m_rsp_id = e.id; m_rsp_x = e.x; m_rsp_y = e.y; m_rsp_z = e.z;
      end else begin
        check_eq("rsp_idle_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rsp_hold_xy", {rsp_x, rsp_y}, {m_rsp_x, m_rsp_y});
        check_eq("rsp_hold_zid", {14'd0, rsp_id, rsp_z}, {14'd0, m_rsp_id, m_rsp_z});
      end
      check_eq("cp_xy", {cp_x0, cp_y0}, {m_cp_x, m_cp_y});
      check_eq("cp_z", {16'd0, cp_z0}, {16'd0, m_cp_z});
      m_pick = -1;
      for (int k = 1; k <= 4; k++) begin
        cand = (int'(m_last) + k) % 4;
        if (m_pick < 0 && en && req_valid[cand]) m_pick = cand;
      end
      m_ready = 4'b0000;
      if (m_pick >= 0) m_ready[m_pick] = 1'b1;
      check_eq("req_ready", {28'd0, req_ready}, {28'd0, m_ready});
      if (m_pick >= 0) begin
        e.due = cyc + L + 2;
        e.id  = 2'(m_pick);
        e.x   = req_x[m_pick*W +: W] + 16'd1;
        e.y   = req_y[m_pick*W +: W] + 16'd2;
        e.z   = req_z[m_pick*W +: W] + 16'd3;
        sb_q.push_back(e);
        m_last = 2'(m_pick);
        m_cp_x = req_x[m_pick*W +: W];
        m_cp_y = req_y[m_pick*W +: W];
        m_cp_z = req_z[m_pick*W +: W];
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
    req_x[i*W +: W] = x;
    req_y[i*W +: W] = y;
    req_z[i*W +: W] = z;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; req_valid = 4'b0000;
    req_x = '0; req_y = '0; req_z = '0;
    step(2);
    rst_n = 1'b1;
    step(1);

    // Single request from requester 0.
    set_ops(0, 16'h0400, 16'h0000, 16'h0324);
    req_valid = 4'b0001;
    step(1);
    req_valid = 4'b0000;
    step(L + 4);

    // Requester 3 once so that the four-way rotation starts at 0.
    set_ops(3, 16'h0333, 16'h0033, 16'h0003);
    req_valid = 4'b1000;
    step(1);
    req_valid = 4'b0000;
    step(2);

    // All four contending for 8 cycles.
    for (int i = 0; i < 4; i++) set_ops(i, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'h3000 + 16'(i));
    req_valid = 4'b1111;
    step(8);
    req_valid = 4'b0000;
    step(L + 4);

    // Requester 2 alone, back-to-back.
    set_ops(2, 16'h0222, 16'h0202, 16'h0022);
    req_valid = 4'b0100;
    step(5);
    req_valid = 4'b0000;
    step(L + 4);

    // en dropped with 1 and 3 contending and results in flight.
    set_ops(1, 16'h0111, 16'h0101, 16'h0011);
    set_ops(3, 16'h0313, 16'h0303, 16'h0033);
    req_valid = 4'b1010;
    step(3);
    en = 1'b0;
    step(3);
    en = 1'b1;
    step(3);
    req_valid = 4'b0000;
    step(L + 4);

    // Reset with four results in flight; first request afterwards from requester 1.
    set_ops(1, 16'h0a11, 16'h0b11, 16'h0c11);
    req_valid = 4'b1111;
    step(4);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    req_valid = 4'b0010;
    step(1);
    req_valid = 4'b0000;
    step(L + 4);

    // One transaction then a long idle window.
    set_ops(0, 16'h0123, 16'h0456, 16'h0789);
    req_valid = 4'b0001;
    step(1);
    req_valid = 4'b0000;
    step(2 * L + 4);

    for (int i = 0; i < 100 && sb_q.size() > 0; i++) step(1);
    check_eq("drain", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_arbiter.md
# cordic_arbiter

Round-robin front-end that shares one `cordic_pipeline` instance between four requesters. It accepts Q6.10 operand triples (x, y, z) over valid/ready handshakes and issues at most one triple per clock into the pipeline. A tag of LATENCY stages follows each issued triple, and the controller returns each pipeline result to the requester that issued it, together with that requester's id. The block sits between the CORDIC clients and the `cordic_pipeline` datapath, which has no reset and no stall input.

## Interface
Parameters:
- `W`, 16, operand/result width (Q6.10 fixed point; passed through unmodified)
- `LATENCY`, 16, cycles from a change on `cp_x0/cp_y0/cp_z0` to the matching `cp_out_*`; must be ≥1

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  grant enable; while low, no new grants are made and in-flight results still return
- `req_valid`  in  4  per-requester operand valid
- `req_ready`  out  4  per-requester grant; combinational, one-hot or zero
- `req_x`, `req_y`, `req_z`  in  4*W each  operands; requester i uses bits [i*W +: W]
- `cp_x0`, `cp_y0`, `cp_z0`  out  W each  registered operands to `cordic_pipeline`
- `cp_out_x`, `cp_out_y`, `cp_out_z`  in  W each  results from `cordic_pipeline`
- `rsp_valid`  out  1  registered one-cycle result strobe
- `rsp_id`  out  2  id of the requester that owns the result
- `rsp_x`, `rsp_y`, `rsp_z`  out  W each  registered result

## Operation
- Arbitration: round-robin over `req_valid & {4{en}}`.
  - Search order starts at `last+1` (mod 4). `last` is the most recent granted id.
  - `req_ready[i]` is high only for the single winner. It depends on `req_valid` and `en`.
  - Handshake for requester i: `req_valid[i] & req_ready[i]` sampled at a rising edge.
- On a handshake:
  - `cp_x0/cp_y0/cp_z0` load the winner's operands.
  - Tag stage 0 loads {1, id}.
  - `last` loads the id.
- With no handshake:
  - `cp_*` hold their value.
  - Tag stage 0 loads {0, x}.
  - `last` holds.
- Tag pipe: LATENCY-stage shift register of {valid, id}. It advances every cycle and is never stalled.
- Return: on every edge, the rsp registers load from the tag pipe and pipeline outputs:
  - `rsp_valid` ← last tag stage valid
  - `rsp_id` ← its id
  - `rsp_x/y/z` ← `cp_out_x/y/z`
  - When the tag is invalid, `rsp_x/y/z` and `rsp_id` hold their previous values.
- No backpressure on the response side. Consumers must accept `rsp_valid` in the cycle it is high.
- Results are returned in issue order. Throughput is one result per cycle.
- `en` low: grants stop the same cycle, because `req_ready` is combinational. Tags already in flight drain normally.

## Timing
- Reset values (async, on `rst_n` low):
  - `req_ready` = 0 while `rst_n` is low
  - `cp_x0/cp_y0/cp_z0` = 0
  - all tag stages invalid
  - `rsp_valid` = 0
  - `rsp_id` = 0
  - `rsp_x/y/z` = 0
  - `last` = 3, so requester 0 wins first
- Latency: handshake at edge k puts the operands on `cp_*` after edge k. `rsp_valid` is high in the cycle following edge k+LATENCY+1, i.e. LATENCY+1 cycles after the handshake.
- Back-to-back issue: grants on consecutive edges give `rsp_valid` on consecutive cycles with ids in grant order.
- Single requester continuously valid: granted every cycle, since it is the only contender.
- Simultaneous requests: at most one grant per cycle. Rotation is fair, so each of n contenders is granted once every n cycles.
- Reset mid-operation: all in-flight tags are discarded and no `rsp_valid` is produced for them. The pipeline is not reset, and its stale contents are ignored because their tags are invalid.
- Deassertion of `rst_n` is synchronised externally. The first grant is possible at the first edge after release.

## Test plan
Benches use a behavioural stub of `cordic_pipeline`: a delay line of LATENCY stages returning (x+1, y+2, z+3).

- Single request: requester 0, x=0x0400, y=0x0000, z=0x0324.
  - Required: `req_ready[0]` is high for 1 cycle.
  - Required: LATENCY+1 cycles later, `rsp_valid`=1, `rsp_id`=0, rsp=(0x0401, 0x0002, 0x0327).
- All four valid for 8 cycles, each with distinct x = 0x1000+i.
  - Required: grant order 0,1,2,3,0,1,2,3.
  - Required: `rsp_id` sequence matches the grant order, and each `rsp_x` equals that requester's x+1.
- Requester 2 only, continuously valid for 5 cycles.
  - Required: 5 consecutive grants and 5 consecutive `rsp_valid` cycles with id 2.
- `en` dropped for 3 cycles while requesters 1 and 3 are valid, with transactions in flight.
  - Required: no `req_ready` during those cycles.
  - Required: in-flight results are still returned.
  - Required: after `en` rises, rotation resumes from `last+1`.
- `rst_n` pulsed low while 4 results are in flight.
  - Required: all outputs read 0 immediately.
  - Required: no `rsp_valid` for the discarded transactions.
  - Required: the first post-reset request (requester 1 only) gets id 1 and is returned after LATENCY+1 cycles.
- No requests for 2*LATENCY cycles after a single transaction.
  - Required: `rsp_valid` pulses exactly once.
  - Required: `cp_*` and `rsp_x/y/z` hold their last values.
